pipe_hzd_ctrl: RTL

//  Hazard/sequencing controller for the 5-stage non-forwarding RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipe_hzd_ctrl_pkg.sv | 32 +++
 rtl/pipe_hzd_ctrl_raw_match.sv | 30 +++
 rtl/pipe_hzd_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hzd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types for the pipeline hazard/sequencing controller.
// Revision : 1.0
// ============================================================================
package pipe_ctrl_pkg;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wren;
    } stg_shadow_t;

    localparam logic [4:0]  REG_X0        = 5'd0;
    localparam stg_shadow_t SHADOW_BUBBLE = '{vld: 1'b0, rd: REG_X0, wren: 1'b0};

    typedef enum logic [2:0] {
        MODE_RESET    = 3'd0,
        MODE_LSU_WAIT = 3'd1,
        MODE_BRANCH   = 3'd2,
        MODE_RAW      = 3'd3,
        MODE_RUN      = 3'd4
    } ctl_mode_t;

    // A stage can only produce a hazard if it will really write a non-x0 register.
    function automatic logic is_writer(input stg_shadow_t s);
        return s.vld && s.wren && (s.rd != REG_X0);
    endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hzd_ctrl_raw_match.sv
`default_nettype none
// ============================================================================
// Module   : hzd_raw_match
// Brief    : Compares the ID source operands against one stage shadow.
// Revision : 1.0
// ============================================================================
module hzd_raw_match
    import pipe_ctrl_pkg::*;
(
    input  logic        i_id_vld,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    input  stg_shadow_t i_stg,
    output logic        o_hit
);

    logic w_live;
    logic w_hit_rs1;
    logic w_hit_rs2;

    // rd != x0 is guaranteed by is_writer, so an equal source is never x0.
    assign w_live    = i_id_vld && is_writer(i_stg);
    assign w_hit_rs1 = i_rs1_used && (i_rs1_addr == i_stg.rd);
    assign w_hit_rs2 = i_rs2_used && (i_rs2_addr == i_stg.rd);
    assign o_hit     = w_live && (w_hit_rs1 || w_hit_rs2);

endmodule : hzd_raw_match
`default_nettype wire

// File: rtl/pipe_hzd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hzd_ctrl
// Brief    : Stall/flush sequencing and performance counters for a 5-stage
//            non-forwarding pipeline.
// Revision : 1.0
// ============================================================================
module pipe_hzd_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGFILE_WT = 1,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_id_vld,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_id_rd_addr,
    input  logic             i_id_rd_wren,
    input  logic             i_ex_br_taken,
    input  logic             i_lsu_busy,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_flush,
    output logic             o_insn_vld,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_nop_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    stg_shadow_t      r_ex;
    stg_shadow_t      r_mem;
    stg_shadow_t      r_wb;
    stg_shadow_t      w_id_shadow;
    logic             w_hit_ex;
    logic             w_hit_mem;
    logic             w_hit_wb;
    logic             w_raw;
    ctl_mode_t        w_mode;
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic             w_nop_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_nop_cnt;

    assign w_id_shadow = '{vld: i_id_vld, rd: i_id_rd_addr, wren: i_id_rd_wren};

    hzd_raw_match u_raw_ex (
        .i_id_vld   (i_id_vld),
        .i_rs1_addr (i_id_rs1_addr),
        .i_rs2_addr (i_id_rs2_addr),
        .i_rs1_used (i_id_rs1_used),
        .i_rs2_used (i_id_rs2_used),
        .i_stg      (r_ex),
        .o_hit      (w_hit_ex)
    );

    hzd_raw_match u_raw_mem (
        .i_id_vld   (i_id_vld),
        .i_rs1_addr (i_id_rs1_addr),
        .i_rs2_addr (i_id_rs2_addr),
        .i_rs1_used (i_id_rs1_used),
        .i_rs2_used (i_id_rs2_used),
        .i_stg      (r_mem),
        .o_hit      (w_hit_mem)
    );

    // Without write-through the WB producer is not yet visible to the ID read.
    generate
        if (REGFILE_WT == 0) begin : g_wb_chk
            hzd_raw_match u_raw_wb (
                .i_id_vld   (i_id_vld),
                .i_rs1_addr (i_id_rs1_addr),
                .i_rs2_addr (i_id_rs2_addr),
                .i_rs1_used (i_id_rs1_used),
                .i_rs2_used (i_id_rs2_used),
                .i_stg      (r_wb),
                .o_hit      (w_hit_wb)
            );
        end else begin : g_wb_skip
            logic w_unused_wb;
            assign w_unused_wb = ^{r_wb.rd, r_wb.wren};
            assign w_hit_wb    = 1'b0;
        end
    endgenerate

    assign w_raw = w_hit_ex || w_hit_mem || w_hit_wb;

    // A memory wait freezes everything upstream, so a resolved branch waits for it.
    always_comb begin
        w_mode = MODE_RUN;
        if (!i_rstn) begin
            w_mode = MODE_RESET;
        end else if (i_lsu_busy) begin
            w_mode = MODE_LSU_WAIT;
        end else if (i_ex_br_taken) begin
            w_mode = MODE_BRANCH;
        end else if (w_raw) begin
            w_mode = MODE_RAW;
        end
    end

    always_comb begin
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_flush = 1'b0;
        case (w_mode)
            MODE_RESET: begin
                o_pc_en        = 1'b0;
                o_if_id_en     = 1'b0;
                o_if_id_flush  = 1'b1;
                o_id_ex_en     = 1'b0;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_en    = 1'b0;
                o_mem_wb_flush = 1'b1;
            end
            MODE_LSU_WAIT: begin
                o_pc_en        = 1'b0;
                o_if_id_en     = 1'b0;
                o_id_ex_en     = 1'b0;
                o_ex_mem_en    = 1'b0;
                o_mem_wb_flush = 1'b1;
            end
            MODE_BRANCH: begin
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
            end
            MODE_RAW: begin
                o_pc_en        = 1'b0;
                o_if_id_en     = 1'b0;
                o_id_ex_flush  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ex  <= SHADOW_BUBBLE;
            r_mem <= SHADOW_BUBBLE;
            r_wb  <= SHADOW_BUBBLE;
        end else begin
            case (w_mode)
                MODE_LSU_WAIT: begin
                    r_wb <= SHADOW_BUBBLE;
                end
                MODE_BRANCH, MODE_RAW: begin
                    r_ex  <= SHADOW_BUBBLE;
                    r_mem <= r_ex;
                    r_wb  <= r_mem;
                end
                default: begin
                    r_ex  <= w_id_shadow;
                    r_mem <= r_ex;
                    r_wb  <= r_mem;
                end
            endcase
        end
    end

    assign w_stall_evt = (w_mode == MODE_LSU_WAIT) || (w_mode == MODE_RAW);
    assign w_flush_evt = (w_mode == MODE_BRANCH);
    assign w_nop_evt   = !r_wb.vld;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_nop_cnt   <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_flush_evt && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
            if (w_nop_evt && (r_nop_cnt != c_cnt_max)) begin
                r_nop_cnt <= r_nop_cnt + c_cnt_one;
            end
        end
    end

    assign o_insn_vld  = r_wb.vld;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_nop_cnt   = r_nop_cnt;

endmodule : pipe_hzd_ctrl
`default_nettype wire
